aes_decipher_sched: RTL and testbench
=====================================

// Module: aes_decipher_sched
// PURPOSE
//  Shares one aes_decipher_block between two requesters (ch0, ch1), using round-robin arbitration.
//  Captures the winner's ciphertext and keylen and pulses core_next.
//  Waits for the core to finish, then returns the plaintext on a valid/ready response channel.
//  Drives key_sel so the external key-memory mux supplies the winner's round keys.
// PARAMETERS
//  CNT_W  16  width of per-channel completion counters (used only with AES_DEC_SCHED_STATS_EN)
// PORTS
//  clk             in   1    clock, all state on rising edge
//  reset_n         in   1    asynchronous active-low reset
//  req0_valid      in   1    ch0 request present
//  req0_ready      out  1    ch0 request accepted (1-cycle pulse in grant cycle)
//  req0_keylen     in   2    ch0 key length: 0=128, 1=192, 2=256
//  req0_block      in   128  ch0 ciphertext
//  req1_valid/req1_ready/req1_keylen/req1_block   as ch0, for ch1
//  rsp_valid       out  1    result available
//  rsp_ready       in   1    consumer accepts result
//  rsp_id          out  1    channel that owns the result
//  rsp_block       out  128  plaintext
//  key_sel         out  1    channel whose key memory feeds core round_key
//  core_next       out  1    start pulse to decipher core
//  core_keylen     out  2    keylen to core
//  core_block      out  128  ciphertext to core
//  core_ready      in   1    core ready (1 when idle)
//  core_new_block  in   128  core result
//  done_cnt0       out  CNT_W  ch0 completed responses (stats build only)
//  done_cnt1       out  CNT_W  ch1 completed responses (stats build only)
// BEHAVIOUR
//  Reset values:
//   - All outputs 0 except key_sel=0. FSM=IDLE; last_grant=1, so ch0 wins the first tie.
//   - Holding regs blk_q, keylen_q, id_q are cleared to 0.
//  FSM states: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> RESP -> IDLE.
//  IDLE:
//   - Grant only when core_ready=1 and at least one reqN_valid=1.
//   - Single requester: that channel wins.
//   - Both requesting: the channel != last_grant wins.
//   - Grant cycle: reqN_ready=1 (combinational, this cycle only); capture blk_q, keylen_q, id_q.
//   - Update last_grant; go to ISSUE.
//  ISSUE: core_next=1 for exactly one cycle; go to WAIT_BUSY.
//  WAIT_BUSY: stay until core_ready=0, then go to WAIT_DONE (normally 1 cycle).
//  WAIT_DONE: on core_ready=1, latch core_new_block into rsp_block, set rsp_valid=1, go to RESP.
//  RESP:
//   - Hold rsp_valid, rsp_id and rsp_block stable until rsp_valid&&rsp_ready.
//   - Then rsp_valid=0 on the next edge; go to IDLE.
//   - The earliest next grant is the cycle after rsp_valid falls; no operation overlaps another.
//  Outputs driven from holding regs:
//   - core_block=blk_q, core_keylen=keylen_q, key_sel=id_q.
//   - These stay stable from ISSUE through WAIT_DONE.
//   - Requesters may change inputs after the grant.
//  Latency:
//   - Grant to core_next is 1 cycle.
//   - rsp_valid rises 1 cycle after core_ready returns high.
//  keylen=3 is forwarded unchanged (the core treats it as 128-bit).
//  reqN_valid dropping before grant is legal; that channel is simply not granted.
//  Asynchronous reset at any point aborts the operation and restores reset values.
//   - The result in flight is lost.
//   - The core shares reset_n, so core and scheduler stay consistent.
// CONFIGURATION
//  AES_DEC_SCHED_STATS_EN defined:
//   - done_cnt0/1 increment on each rsp_valid&&rsp_ready handshake for rsp_id 0/1.
//   - Counters wrap from 2^CNT_W-1 to 0 and reset to 0.
//  Not defined:
//   - done_cnt0/1 are tied to 0 and no counter flops exist.
//   - All other behaviour is identical.
// TESTING
//  1. Reset, then ch0 only:
//     - Stimulus: keylen=0, block=69c4e0d86a7b0430d8cdb78070b4c55a; key mem0=000102..0f.
//     - Response: rsp_id=0, rsp_block=00112233445566778899aabbccddeeff, key_sel=0 while busy.
//  2. ch0 and ch1 valid together, held for 4 transactions:
//     - Response: grant order 0,1,0,1; each rsp_id matches its channel's expected plaintext.
//  3. Back-pressure: hold rsp_ready=0 for 20 cycles after rsp_valid.
//     - rsp_block/rsp_id stay stable; no new reqN_ready; core_next stays 0 until release.
//  4. Change req0_block the cycle after grant:
//     - core_block keeps the captured value; the result matches the original ciphertext.
//  5. Assert reset_n=0 during WAIT_DONE:
//     - All outputs return to reset values immediately; FSM goes to IDLE.
//     - After release, the first tie is granted to ch0.
//  6. Stats build, 3 ch1 transactions:
//     - done_cnt1=3, done_cnt0=0.
//     - Non-stats build: both counters read 0.

Source files
------------

// File: rtl/aes_decipher_sched.sv
// aes_decipher_sched: round-robin scheduler that shares one AES decipher core
// between two requesters. It captures the winning request, pulses core_next,
// waits for the core to finish and returns the plaintext on a valid/ready channel.
// Optional build macro: AES_DEC_SCHED_STATS_EN adds per-channel completion counters.
module aes_decipher_sched #(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [1:0]         req0_keylen,
    input  logic [127:0]       req0_block,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [1:0]         req1_keylen,
    input  logic [127:0]       req1_block,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [127:0]       rsp_block,
    output logic               key_sel,
    output logic               core_next,
    output logic [1:0]         core_keylen,
    output logic [127:0]       core_block,
    input  logic               core_ready,
    input  logic [127:0]       core_new_block,
    output logic [CNT_W-1:0]   done_cnt0,
    output logic [CNT_W-1:0]   done_cnt1
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic           last_grant_q;
    logic           id_q;
    logic [1:0]     keylen_q;
    logic [127:0]   blk_q;
    logic           core_next_q;
    logic           rsp_valid_q;
    logic [127:0]   rsp_block_q;

    logic           grant_c;
    logic           grant_id_c;
    logic           rsp_load_c;
    logic           rsp_fire_c;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, arbitration and datapath strobes.
    always_comb begin
        state_d    = state_q;
        grant_c    = 1'b0;
        grant_id_c = 1'b0;
        rsp_load_c = 1'b0;
        rsp_fire_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (core_ready && (req0_valid || req1_valid)) begin
                    grant_c    = 1'b1;
                    // On a tie the channel that did not win last time goes next.
                    grant_id_c = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!core_ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (core_ready) begin
                    rsp_load_c = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_fire_c = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request capture, core start pulse and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            keylen_q     <= 2'd0;
            blk_q        <= 128'd0;
            core_next_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_block_q  <= 128'd0;
        end else begin
            core_next_q <= grant_c;
            if (grant_c) begin
                last_grant_q <= grant_id_c;
                id_q         <= grant_id_c;
                keylen_q     <= grant_id_c ? req1_keylen : req0_keylen;
                blk_q        <= grant_id_c ? req1_block : req0_block;
            end
            if (rsp_load_c) begin
                rsp_valid_q <= 1'b1;
                rsp_block_q <= core_new_block;
            end else if (rsp_fire_c) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // Grant handshake is combinational so the requester sees it in the grant cycle.
    assign req0_ready  = grant_c && !grant_id_c;
    assign req1_ready  = grant_c && grant_id_c;

    // Core-facing and response outputs come straight from holding registers.
    assign core_next   = core_next_q;
    assign core_block  = blk_q;
    assign core_keylen = keylen_q;
    assign key_sel     = id_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_block   = rsp_block_q;
    assign rsp_id      = id_q;

`ifdef AES_DEC_SCHED_STATS_EN
    logic [CNT_W-1:0] done_cnt0_q;
    logic [CNT_W-1:0] done_cnt1_q;

    // Completed-response counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_cnt0_q <= '0;
            done_cnt1_q <= '0;
        end else if (rsp_fire_c) begin
            if (id_q) begin
                done_cnt1_q <= done_cnt1_q + CNT_W'(1);
            end else begin
                done_cnt0_q <= done_cnt0_q + CNT_W'(1);
            end
        end
    end

    assign done_cnt0 = done_cnt0_q;
    assign done_cnt1 = done_cnt1_q;
`else
    assign done_cnt0 = '0;
    assign done_cnt1 = '0;
`endif

endmodule

// File: tb/tb_aes_decipher_sched.sv
// Bench for aes_decipher_sched with a behavioural decipher core stand-in.
// Define AES_DEC_SCHED_STATS_EN to exercise the counter build.
module tb_aes_decipher_sched;

    localparam int unsigned CNT_W = 16;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]       req0_keylen, req1_keylen, core_keylen;
    logic [127:0]     req0_block, req1_block, rsp_block, core_block, core_new_block;
    logic             rsp_valid, rsp_ready, rsp_id, key_sel, core_next, core_ready;
    logic [CNT_W-1:0] done_cnt0, done_cnt1;

    typedef struct packed {
        logic         id;
        logic [127:0] blk;
    } rsp_t;

    rsp_t resp_q[$];
    logic exp_g[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   gcnt  = 0;
    int   stab_bad = 0;

    always #5 clk = ~clk;

    aes_decipher_sched #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_keylen(req0_keylen), .req0_block(req0_block),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_keylen(req1_keylen), .req1_block(req1_block),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_block(rsp_block),
        .key_sel(key_sel), .core_next(core_next), .core_keylen(core_keylen), .core_block(core_block),
        .core_ready(core_ready), .core_new_block(core_new_block),
        .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    // Core stand-in: key memory 0 holds the FIPS-197 128-bit key, key memory 1 the 192-bit key.
    // Known vectors decrypt to PT with the right key/keylen; anything else maps to a tagged value.
    function automatic logic [127:0] core_model(input logic [127:0] b, input logic [1:0] kl, input logic sel);
        if (!sel && kl == 2'd0 && b == C128) return PT;
        if (sel && kl == 2'd1 && b == C192) return PT;
        return ~b ^ {sel, 125'd0, kl};
    endfunction

    logic [2:0]   lat_cnt;
    logic [127:0] cap_b;
    logic [1:0]   cap_k;
    logic         cap_s;

    // Behavioural decipher core: drops ready on core_next, returns result after a few cycles.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_ready     <= 1'b1;
            core_new_block <= '0;
            lat_cnt        <= 3'd0;
        end else if (core_ready) begin
            if (core_next) begin
                core_ready <= 1'b0;
                lat_cnt    <= 3'd5;
                cap_b      <= core_block;
                cap_k      <= core_keylen;
                cap_s      <= key_sel;
            end
        end else if (lat_cnt == 3'd1) begin
            core_ready     <= 1'b1;
            core_new_block <= core_model(cap_b, cap_k, cap_s);
        end else begin
            lat_cnt <= lat_cnt - 3'd1;
        end
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitor: grant order, core-side stability while busy, response scoreboard.
    logic [127:0] trk_b;
    logic [1:0]   trk_k;
    logic         trk_s, trk;
    always @(negedge clk) begin
        if (!reset_n) begin
            trk = 1'b0;
        end else begin
            if (req0_ready || req1_ready) begin
                gcnt++;
                if (exp_g.size() == 0) begin
                    chk("grant_unexpected", 128'(req1_ready), 128'(1'bx));
                end else begin
                    chk("grant_id", 128'({req0_ready, req1_ready}), 128'({~exp_g[0], exp_g[0]}));
                    void'(exp_g.pop_front());
                end
            end
            if (core_next) begin
                trk = 1'b1; trk_b = core_block; trk_k = core_keylen; trk_s = key_sel;
            end else if (trk) begin
                if (core_block !== trk_b || core_keylen !== trk_k || key_sel !== trk_s) stab_bad++;
                if (rsp_valid) trk = 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                if (resp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_block, 128'hx);
                end else begin
                    chk("rsp_id", 128'(rsp_id), 128'(resp_q[0].id));
                    chk("rsp_block", rsp_block, resp_q[0].blk);
                    void'(resp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n);
        int start;
        start = gcnt;
        for (int i = 0; i < 300 && gcnt < start + n; i++) tick();
        chk("grant_timeout", 128'(gcnt >= start + n), 128'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (resp_q.size() != 0 || rsp_valid); i++) tick();
        chk("drain_timeout", 128'(resp_q.size() == 0 && !rsp_valid), 128'(1));
    endtask

    task automatic push_rsp(input logic id, input logic [127:0] blk);
        rsp_t r;
        r.id  = id;
        r.blk = blk;
        resp_q.push_back(r);
    endtask

    // Single request on one channel; returns one cycle after the grant edge (ISSUE state).
    task automatic do_req(input logic ch, input logic [127:0] blk, input logic [1:0] kl);
        exp_g.push_back(ch);
        push_rsp(ch, core_model(blk, kl, ch));
        if (ch) begin req1_valid = 1'b1; req1_block = blk; req1_keylen = kl; end
        else    begin req0_valid = 1'b1; req0_block = blk; req0_keylen = kl; end
        wait_grants(1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
        chk({nm, "_core_next"}, 128'(core_next), 128'(0));
        chk({nm, "_key_sel"}, 128'(key_sel), 128'(0));
        chk({nm, "_core_block"}, core_block, 128'd0);
        chk({nm, "_core_keylen"}, 128'(core_keylen), 128'(0));
        chk({nm, "_rsp_block"}, rsp_block, 128'd0);
        chk({nm, "_rsp_id"}, 128'(rsp_id), 128'(0));
    endtask

    initial begin
        int bad;
        logic [127:0] hold_b;
        logic hold_id;
        reset_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        req0_keylen = 2'd0; req1_keylen = 2'd0; req0_block = '0; req1_block = '0;
        tick(); tick();
        check_reset_outputs("reset");
        chk("reset_ready", 128'({req0_ready, req1_ready}), 128'(0));
        reset_n = 1'b1;
        tick();

        // ch0 alone, FIPS-197 128-bit vector.
        do_req(1'b0, C128, 2'd0);
        chk("t1_core_next_latency", 128'(core_next), 128'(1));
        chk("t1_key_sel", 128'(key_sel), 128'(0));
        chk("t1_core_block", core_block, C128);
        drain();

        // ch1 alone with keylen=3 forwarded unchanged.
        do_req(1'b1, 128'h0123456789abcdeffedcba9876543210, 2'd3);
        chk("kl3_core_keylen", 128'(core_keylen), 128'(3));
        chk("kl3_key_sel", 128'(key_sel), 128'(1));
        drain();

        // Both channels held for four transactions: alternating grants starting at ch0.
        req0_block = C128; req0_keylen = 2'd0;
        req1_block = C192; req1_keylen = 2'd1;
        for (int i = 0; i < 4; i++) begin
            exp_g.push_back(1'(i % 2));
            push_rsp(1'(i % 2), PT);
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_grants(4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Back-pressure for 20 cycles with a competing request pending.
        rsp_ready = 1'b0;
        do_req(1'b0, 128'hcafef00d_00000000_11111111_deadbeef, 2'd2);
        exp_g.push_back(1'b1);
        push_rsp(1'b1, core_model(128'h5555aaaa_12345678_9abcdef0_0f0f0f0f, 2'd0, 1'b1));
        req1_block = 128'h5555aaaa_12345678_9abcdef0_0f0f0f0f; req1_keylen = 2'd0; req1_valid = 1'b1;
        for (int i = 0; i < 100 && !rsp_valid; i++) tick();
        chk("bp_rsp_valid", 128'(rsp_valid), 128'(1));
        hold_b = rsp_block; hold_id = rsp_id;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!rsp_valid || rsp_block !== hold_b || rsp_id !== hold_id ||
                core_next || req0_ready || req1_ready) bad++;
        end
        chk("bp_stable_cycles_bad", 128'(bad), 128'(0));
        rsp_ready = 1'b1;
        wait_grants(1);
        req1_valid = 1'b0;
        drain();

        // Requester changes its block right after the grant.
        do_req(1'b0, 128'h00000000_00000000_00000000_000000a5, 2'd1);
        req0_block = 128'hffffffff_ffffffff_ffffffff_ffffff00;
        tick();
        chk("t4_core_block_held", core_block, 128'h00000000_00000000_00000000_000000a5);
        drain();

        // Reset while the core is busy (WAIT_DONE): operation is abandoned.
        exp_g.push_back(1'b0);
        req0_block = 128'h13579bdf_2468ace0_fedcba98_76543210; req0_keylen = 2'd2; req0_valid = 1'b1;
        wait_grants(1);
        req0_valid = 1'b0;
        tick(); tick(); tick();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        tick(); tick();
        reset_n = 1'b1;
        tick();
        req0_block = C128; req0_keylen = 2'd0;
        req1_block = C192; req1_keylen = 2'd1;
        exp_g.push_back(1'b0); exp_g.push_back(1'b1);
        push_rsp(1'b0, PT); push_rsp(1'b1, PT);
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_grants(2);
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Three ch1 completions after a fresh reset.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            do_req(1'b1, 128'(i + 7), 2'd0);
            drain();
        end
`ifdef AES_DEC_SCHED_STATS_EN
        chk("done_cnt1", 128'(done_cnt1), 128'(3));
`else
        chk("done_cnt1", 128'(done_cnt1), 128'(0));
`endif
        chk("done_cnt0", 128'(done_cnt0), 128'(0));

        chk("core_side_stability_bad", 128'(stab_bad), 128'(0));
        chk("grants_outstanding", 128'(exp_g.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global bound in case a wait slips through.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
